cl_axil_bram_ctrl: RTL and testbench
====================================

Name: cl_axil_bram_ctrl

Overview:
AXI4-Lite slave that fronts the dual-port 256x32 BRAM used for host-to-systolic data staging. Host writes are turned into port-A write strobes; host reads are turned into port-B read cycles. Port-B read data is captured and returned on the R channel. The block sits directly upstream of the BRAM wrapper: it drives the port-A write and port-B read signals and consumes port-B read data.

Parameters:
DATA_W, 32, AXI-Lite and BRAM data width
DEPTH, 256, BRAM depth in words; word index is valid when less than DEPTH
BRAM_AW, 32, width of the BRAM address ports
OOR_DATA, 32'hDEAD_BEEF, rdata returned for an out-of-range read

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous active-low reset
awaddr  in  32  write address (byte)
awvalid / awready  in / out  1  write-address handshake
wdata  in  32  write data
wstrb  in  4  write strobes
wvalid / wready  in / out  1  write-data handshake
bresp  out  2  write response (00 OKAY, 10 SLVERR)
bvalid / bready  out / in  1  write-response handshake
araddr  in  32  read address (byte)
arvalid / arready  in / out  1  read-address handshake
rdata  out  32  read data
rresp  out  2  read response
rvalid / rready  out / in  1  read-data handshake
bram_we_a  out  1  port-A write enable
bram_en_a  out  1  port-A enable
bram_addr_a  out  BRAM_AW  port-A word address
bram_wdata_a  out  32  port-A write data
bram_en_b  out  1  port-B enable (port-B write enable is tied 0 by the integrator)
bram_addr_b  out  BRAM_AW  port-B word address
bram_rdata_b  in  32  port-B read data, valid one cycle after bram_en_b

Behaviour:
- Reset (async assert, sync deassert edge): all ready/valid/enable outputs are 0; bresp, rresp, rdata and BRAM addr/data are 0; both FSMs return to IDLE. The first cycle after release, awready, wready and arready are 1.
- Reset mid-operation drops bram_en_a/we_a immediately, so no write occurs. Pending B/R responses are discarded.
- Address mapping: word index = addr[31:2] zero-extended to BRAM_AW. addr[1:0] is ignored.
- Write FSM states are W_IDLE, W_BRAM and W_RESP.
  - W_IDLE: AW and W are accepted independently. awready drops once AW is latched; wready drops once W is latched.
  - When both are latched, go to W_BRAM.
  - W_BRAM lasts one cycle: en_a=we_a=1 with the latched addr/data.
  - A write is suppressed (en_a=0, bresp=SLVERR) if wstrb != 4'hF or the index is >= DEPTH.
  - W_RESP: bvalid=1, held until bready; then go to W_IDLE with awready=wready=1.
  - Latency: AW and W in the same cycle T means the BRAM write occurs in T+1 and bvalid rises in T+2.
- Read FSM states are R_IDLE, R_ISSUE, R_CAPT and R_RESP.
  - R_IDLE: arready=1. On AR handshake, latch the address and go to R_ISSUE (arready=0).
  - R_ISSUE: en_b=1 for one cycle, then go to R_CAPT.
  - R_CAPT: register bram_rdata_b into rdata, then go to R_RESP.
  - R_RESP: rvalid=1, held until rready; then go to R_IDLE.
  - Latency: AR accepted in T, en_b in T+1, rvalid in T+3.
  - Out-of-range read: no en_b pulse; rdata=OOR_DATA, rresp=SLVERR, same latency.
- Read/write collision: if R_ISSUE and W_BRAM target the same word in the same cycle, R_ISSUE stalls one cycle (en_b=0). The read therefore returns the new data, with rvalid one cycle later.
- Reads and writes otherwise proceed concurrently and independently.
- rdata, rresp, bresp and rvalid/bvalid remain stable while valid is high and ready is low.

Test Plan:
- Reset released, then AW+W at 0x0000_0010 with data 0x1234_5678 and wstrb F in the same cycle -> en_a/we_a at T+1 with addr_a=4; bvalid at T+2 with bresp=00.
- Read 0x10 after that write, with rready=1 -> en_b at T+1 with addr_b=4; rvalid at T+3 with rdata=0x1234_5678 and rresp=00.
- W one cycle before AW, and bready held low 5 cycles -> a single write occurs; bvalid stays high and stable, awready/wready stay 0 until the B handshake.
- Write with wstrb=4'h3, then a write to 0x400 (index 256) -> no en_a pulse; both responses are SLVERR. A read at 0x400 returns 0xDEAD_BEEF with SLVERR.
- Read and write to word 7 collide in the same cycle (old 0xA, new 0xB) -> en_b is delayed one cycle; rdata=0xB; rvalid at T+4.
- rst_n asserted during W_BRAM -> en_a drops immediately; there is no bvalid after release; a subsequent read of that word returns its old value.

Source files
------------

// File: rtl/cl_axil_bram_ctrl.sv
// AXI4-Lite slave that turns host writes into BRAM port-A strobes and host reads
// into port-B read cycles. The write and read paths run as independent FSMs.
module cl_axil_bram_ctrl #(
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 256,
    parameter int                 BRAM_AW  = 32,
    parameter logic [DATA_W-1:0]  OOR_DATA = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [31:0]         araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic                bram_we_a,
    output logic                bram_en_a,
    output logic [BRAM_AW-1:0]  bram_addr_a,
    output logic [DATA_W-1:0]   bram_wdata_a,
    output logic                bram_en_b,
    output logic [BRAM_AW-1:0]  bram_addr_b,
    input  logic [DATA_W-1:0]   bram_rdata_b
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_BRAM, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAPT, R_RESP} r_state_t;

    w_state_t              w_state_q, w_state_d;
    logic                  aw_have_q, aw_have_d;
    logic                  w_have_q, w_have_d;
    logic [BRAM_AW-1:0]    aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;

    r_state_t              r_state_q, r_state_d;
    logic [BRAM_AW-1:0]    ar_idx_q, ar_idx_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic wr_ok;
    logic rd_ok;
    logic collide;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    assign wr_ok   = (&wstrb_q) && (aw_idx_q < BRAM_AW'(DEPTH));
    assign rd_ok   = ar_idx_q < BRAM_AW'(DEPTH);
    // A read issuing to the word being written this cycle waits so it sees the new data.
    assign collide = (w_state_q == W_BRAM) && wr_ok && (aw_idx_q == ar_idx_q);

    always_comb begin
        w_state_d = w_state_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bram_en_a = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready = rst_n && !aw_have_q;
                wready  = rst_n && !w_have_q;
                if (awvalid && awready) begin
                    aw_have_d = 1'b1;
                    aw_idx_d  = BRAM_AW'(awaddr[31:2]);
                end
                if (wvalid && wready) begin
                    w_have_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if (aw_have_d && w_have_d) begin
                    w_state_d = W_BRAM;
                end
            end
            W_BRAM: begin
                bram_en_a = wr_ok;
                bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        ar_idx_d  = ar_idx_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        bram_en_b = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                arready = rst_n;
                if (arvalid && arready) begin
                    ar_idx_d  = BRAM_AW'(araddr[31:2]);
                    r_state_d = R_ISSUE;
                end
            end
            R_ISSUE: begin
                if (!collide) begin
                    bram_en_b = rd_ok;
                    r_state_d = R_CAPT;
                end
            end
            R_CAPT: begin
                rdata_d   = rd_ok ? bram_rdata_b : OOR_DATA;
                rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            ar_idx_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            ar_idx_q  <= ar_idx_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bram_we_a    = bram_en_a;
    assign bram_addr_a  = aw_idx_q;
    assign bram_wdata_a = wdata_q;
    assign bram_addr_b  = ar_idx_q;
    assign bresp        = bresp_q;
    assign rdata        = rdata_q;
    assign rresp        = rresp_q;

endmodule

// File: tb/tb_cl_axil_bram_ctrl.sv
// Randomized bench for cl_axil_bram_ctrl: a behavioural BRAM sits behind the DUT and a
// transaction-level memory model predicts every response, latency and strobe count.
module tb_cl_axil_bram_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        bram_we_a, bram_en_a, bram_en_b;
    logic [31:0] bram_addr_a, bram_wdata_a, bram_addr_b;
    logic [31:0] bram_rdata_b;

    logic [31:0] bram_mem [DEPTH];
    logic [31:0] ref_mem  [DEPTH];
    int          en_a_cnt = 0;
    int          n_cmp = 0;
    int          n_mis = 0;

    cl_axil_bram_ctrl #(
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .BRAM_AW  (32),
        .OOR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .bram_we_a    (bram_we_a),
        .bram_en_a    (bram_en_a),
        .bram_addr_a  (bram_addr_a),
        .bram_wdata_a (bram_wdata_a),
        .bram_en_b    (bram_en_b),
        .bram_addr_b  (bram_addr_b),
        .bram_rdata_b (bram_rdata_b)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port BRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (bram_en_a && bram_we_a) bram_mem[bram_addr_a[7:0]] <= bram_wdata_a;
        if (bram_en_b) bram_rdata_b <= bram_mem[bram_addr_b[7:0]];
        if (bram_en_a) en_a_cnt <= en_a_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, input int bhold);
        bit          aw_done = 0, w_done = 0, aw_acc, w_acc;
        int          cyc = 0;
        int          base;
        logic        ok;
        logic [31:0] idx;
        idx  = {2'b00, addr[31:2]};
        ok   = (strb == 4'hF) && (idx < DEPTH);
        base = en_a_cnt;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = (lead <= 0);
        wvalid  = (lead >= 0);
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_acc) begin aw_done = 1; awvalid = 1'b0; end
            if (w_acc)  begin w_done  = 1; wvalid  = 1'b0; end
            if (w_done && !aw_done) check("wready_after_w", 32'(wready), 32'd0);
            if (aw_done && !w_done) check("awready_after_aw", 32'(awready), 32'd0);
            if (!aw_done && cyc >= lead)  awvalid = 1'b1;
            if (!w_done  && cyc >= -lead) wvalid  = 1'b1;
        end
        check("aw_w_accepted", {30'd0, aw_done, w_done}, 32'd3);
        if (!(aw_done && w_done)) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            return;
        end
        check("en_a", 32'(bram_en_a), 32'(ok));
        check("we_a", 32'(bram_we_a), 32'(ok));
        if (ok) begin
            check("addr_a", bram_addr_a, idx);
            check("wdata_a", bram_wdata_a, data);
            ref_mem[idx[7:0]] = data;
        end
        @(posedge clk); #1;
        check("bvalid_lat", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), ok ? 32'd0 : 32'd2);
        repeat (bhold) begin
            @(posedge clk); #1;
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("bresp_hold", 32'(bresp), ok ? 32'd0 : 32'd2);
            check("aw_w_ready_hold", {30'd0, awready, wready}, 32'd0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clr", 32'(bvalid), 32'd0);
        check("aw_w_ready_back", {30'd0, awready, wready}, 32'd3);
        check("en_a_count", 32'(en_a_cnt - base), 32'(ok));
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rhold, input bit exp_stall);
        logic [31:0] idx, exp_d;
        logic        ok;
        int          cyc = 0;
        int          en_b_at = -1, en_b_n = 0, rv_at = -1;
        idx = {2'b00, addr[31:2]};
        ok  = idx < DEPTH;
        araddr  = addr;
        arvalid = 1'b1;
        while (!arready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ar_accepted", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int k = 1; k <= 8 && rv_at < 0; k++) begin
            if (bram_en_b) begin
                en_b_n++;
                if (en_b_at < 0) en_b_at = k;
                check("addr_b", bram_addr_b, idx);
            end
            if (rvalid) rv_at = k;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rvalid_lat", 32'(rv_at), exp_stall ? 32'd4 : 32'd3);
        check("en_b_count", 32'(en_b_n), 32'(ok));
        if (ok) check("en_b_lat", 32'(en_b_at), exp_stall ? 32'd2 : 32'd1);
        exp_d = ok ? ref_mem[idx[7:0]] : 32'hDEAD_BEEF;
        check("rdata", rdata, exp_d);
        check("rresp", 32'(rresp), ok ? 32'd0 : 32'd2);
        repeat (rhold) begin
            @(posedge clk); #1;
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, exp_d);
            check("rresp_hold", 32'(rresp), ok ? 32'd0 : 32'd2);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clr", 32'(rvalid), 32'd0);
        check("arready_back", 32'(arready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_readies"}, {29'd0, awready, wready, arready}, 32'd0);
        check({tag, "_valids"}, {30'd0, bvalid, rvalid}, 32'd0);
        check({tag, "_bram_en"}, {29'd0, bram_en_a, bram_we_a, bram_en_b}, 32'd0);
        check({tag, "_resp"}, {28'd0, bresp, rresp}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_addr_a"}, bram_addr_a, 32'd0);
        check({tag, "_addr_b"}, bram_addr_b, 32'd0);
        check({tag, "_wdata_a"}, bram_wdata_a, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a_idx, b_idx, a_addr, b_addr, rnd;
        int          op;
        rst_n = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rnd         = $urandom;
            bram_mem[i] = rnd;
            ref_mem[i]  = rnd;
        end
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {29'd0, awready, wready, arready}, 32'd7);

        axi_write(32'h0000_0010, 32'h1234_5678, 4'hF, 0, 0);
        axi_read(32'h0000_0010, 0, 0);
        axi_write(32'h0000_0020, 32'hCAFE_0020, 4'hF, 1, 5);
        axi_read(32'h0000_0020, 3, 0);
        axi_write(32'h0000_0030, 32'h5A5A_5A5A, 4'h3, 0, 0);
        axi_read(32'h0000_0030, 0, 0);
        axi_write(32'h0000_0400, 32'h0BAD_0400, 4'hF, 0, 0);
        axi_read(32'h0000_0400, 2, 0);

        axi_write(32'h0000_001C, 32'h0000_000A, 4'hF, 0, 0);
        fork
            axi_write(32'h0000_001C, 32'h0000_000B, 4'hF, 0, 0);
            axi_read(32'h0000_001C, 0, 1);
        join
        check("collision_new_data", ref_mem[7], 32'h0000_000B);

        axi_write(32'h0000_0024, 32'h5555_0009, 4'hF, 0, 0);
        awaddr = 32'h0000_0024; wdata = 32'h9999_9999; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("en_a_before_rst", 32'(bram_en_a), 32'd1);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("no_bvalid_after_rst", 32'(bvalid), 32'd0);
        end
        axi_read(32'h0000_0024, 0, 0);

        for (int t = 0; t < 80; t++) begin
            op     = $urandom_range(0, 3);
            a_idx  = $urandom_range(0, 299);
            a_addr = {a_idx[29:0], 2'($urandom)};
            rnd    = $urandom;
            if (op == 0) begin
                axi_write(a_addr, rnd, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF,
                          $urandom_range(0, 4) - 2, $urandom_range(0, 3));
            end else if (op == 1) begin
                axi_read(a_addr, $urandom_range(0, 3), 0);
            end else begin
                a_idx  = $urandom_range(0, DEPTH - 1);
                b_idx  = $urandom_range(0, 299);
                if (b_idx == a_idx) b_idx = a_idx + 1;
                a_addr = {a_idx[29:0], 2'b00};
                b_addr = {b_idx[29:0], 2'b00};
                fork
                    axi_write(a_addr, rnd, 4'hF, 0, $urandom_range(0, 2));
                    axi_read(b_addr, $urandom_range(0, 2), 0);
                join
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
